// File: rtl/exec_pkg.sv
// exec_pkg: shared FSM states, ALU/shift opcodes and status bit positions for alu_exec_unit
package exec_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WB} state_t;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational one-bit shifter on B, ALU and {V,N,Z} flag generation
module alu_shifter
  import exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        shift_op_i,
  input  logic [1:0]        alu_op_i,
  output logic [DATA_W-1:0] c_o,
  output logic [2:0]        status_o
);
  logic [DATA_W-1:0] sb;
  logic              msb;
  // shift B, apply the ALU op, then derive flags; V is only meaningful for ADD/SUB
  always_comb begin
    sb = shift_op_i == SH_LSL ? {b_i[DATA_W-2:0], 1'b0} :
         shift_op_i == SH_LSR ? {1'b0, b_i[DATA_W-1:1]} :
         shift_op_i == SH_ASR ? {b_i[DATA_W-1], b_i[DATA_W-1:1]} : b_i;
    c_o = alu_op_i == ALU_ADD ? a_i + sb :
          alu_op_i == ALU_SUB ? a_i - sb :
          alu_op_i == ALU_AND ? a_i & sb : ~sb;
    msb = c_o[DATA_W-1];
    status_o = '0;
    status_o[ST_Z] = c_o == '0;
    status_o[ST_N] = msb;
    status_o[ST_V] = alu_op_i == ALU_ADD ? (a_i[DATA_W-1] == sb[DATA_W-1]) && (msb != a_i[DATA_W-1]) :
                     alu_op_i == ALU_SUB ? (a_i[DATA_W-1] != sb[DATA_W-1]) && (msb != a_i[DATA_W-1]) : 1'b0;
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle read-read-exec-writeback stage around a register file; EXEC_CMP_EN adds a compare-only (no writeback) input cmp
module alu_exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] rd,
  input  logic [1:0]        shift_op,
  input  logic [1:0]        alu_op,
`ifdef EXEC_CMP_EN
  input  logic              cmp,
`endif
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [REG_AW-1:0] rf_readnum,
  output logic [REG_AW-1:0] rf_writenum,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              busy,
  output logic              done,
  output logic [2:0]        status
);
  state_t            state_q;
  logic [REG_AW-1:0] rm_q, rd_q;
  logic [1:0]        sh_q, op_q;
  logic [DATA_W-1:0] a_q, b_q, c_q, alu_c;
  logic [2:0]        alu_st;
`ifdef EXEC_CMP_EN
  logic              cmp_q;
`endif

  alu_shifter #(.DATA_W(DATA_W)) u_alu (
    .a_i(a_q), .b_i(b_q), .shift_op_i(sh_q), .alu_op_i(op_q), .c_o(alu_c), .status_o(alu_st)
  );

  assign rf_data_in = c_q;

  // sequencer: outputs are registered one state ahead so they are clean for the whole state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rm_q        <= '0;
      rd_q        <= '0;
      sh_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      status      <= '0;
      rf_readnum  <= '0;
      rf_writenum <= '0;
      rf_write    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef EXEC_CMP_EN
      cmp_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_RD_A;
          rm_q       <= rm;
          rd_q       <= rd;
          sh_q       <= shift_op;
          op_q       <= alu_op;
          rf_readnum <= rn;
          busy       <= 1'b1;
`ifdef EXEC_CMP_EN
          cmp_q      <= cmp;
`endif
        end
        S_RD_A: begin
          state_q    <= S_RD_B;
          a_q        <= rf_data_out;
          rf_readnum <= rm_q;
        end
        S_RD_B: begin
          state_q    <= S_EXEC;
          b_q        <= rf_data_out;
          rf_readnum <= '0;
        end
        S_EXEC: begin
          state_q     <= S_WB;
          c_q         <= alu_c;
          status      <= alu_st;
          done        <= 1'b1;
          rf_writenum <= rd_q;
`ifdef EXEC_CMP_EN
          rf_write    <= !cmp_q;
`else
          rf_write    <= 1'b1;
`endif
        end
        default: begin
          state_q     <= S_IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          rf_write    <= 1'b0;
          rf_writenum <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: bench with a behavioural regfile and op-level reference model for alu_exec_unit
module tb_alu_exec_unit;
  logic clk = 0, reset = 1, start = 0, cmp = 0;
  logic [2:0] rn = 0, rm = 0, rd = 0;
  logic [1:0] shift_op = 0, alu_op = 0;
  logic [15:0] rf_data_out, rf_data_in;
  logic [2:0] rf_readnum, rf_writenum, status;
  logic rf_write, busy, done;
  logic [15:0] regs [8];
  logic tb_we = 0;
  logic [2:0] tb_wn = 0;
  logic [15:0] tb_wd = 0;
  int checks = 0, failures = 0, done_cnt = 0, wr_cnt = 0;

  alu_exec_unit #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .rd(rd),
    .shift_op(shift_op), .alu_op(alu_op),
`ifdef EXEC_CMP_EN
    .cmp(cmp),
`endif
    .rf_data_out(rf_data_out), .rf_readnum(rf_readnum), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_data_in(rf_data_in), .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  assign rf_data_out = regs[rf_readnum];
  always @(posedge clk) begin
    if (rf_write) regs[rf_writenum] <= rf_data_in;
    else if (tb_we) regs[tb_wn] <= tb_wd;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic void ref_alu(input int a, input int b, input int sh, input int op,
                                  output int r, output logic [2:0] st);
    int sb, sa, ss, full;
    logic v;
    v = 0;
    case (sh)
      0: sb = b;
      1: sb = (b * 2) % 65536;
      2: sb = b / 2;
      default: sb = b / 2 + (b >= 32768 ? 32768 : 0);
    endcase
    sa = a >= 32768 ? a - 65536 : a;
    ss = sb >= 32768 ? sb - 65536 : sb;
    case (op)
      0: begin full = sa + ss; r = (a + sb) % 65536; v = full > 32767 || full < -32768; end
      1: begin full = sa - ss; r = (a - sb + 65536) % 65536; v = full > 32767 || full < -32768; end
      2: r = a & sb;
      default: r = 65535 - sb;
    endcase
    st = {v, r >= 32768, r == 0};
  endfunction

  // reference model: op-level view, phase counts cycles since the accepting edge
  int ph = 0;
  logic [15:0] m_rf [8];
  logic [15:0] m_c = 0;
  logic [2:0] m_st = 0, p_st = 0;
  int p_res = 0;
  logic [2:0] p_rn = 0, p_rm = 0, p_rd = 0;
  logic p_cmp = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = 0; m_c = 0; m_st = 0;
    end else begin
      if (ph == 4) begin
        if (!p_cmp) m_rf[p_rd] = p_res[15:0];
        ph = 0;
      end else if (ph == 3) begin
        m_c = p_res[15:0]; m_st = p_st; ph = 4;
      end else if (ph != 0) ph++;
      else if (start) begin
        p_rn = rn; p_rm = rm; p_rd = rd;
`ifdef EXEC_CMP_EN
        p_cmp = cmp;
`else
        p_cmp = 0;
`endif
        ref_alu(int'(m_rf[rn]), int'(m_rf[rm]), int'(shift_op), int'(alu_op), p_res, p_st);
        ph = 1;
      end
      if (tb_we && ph == 0) m_rf[tb_wn] = tb_wd;
    end
  end

  // compare process: every cycle out of reset, DUT vs model
  always @(negedge clk) if (!reset) begin
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 4);
    chk("rf_write", rf_write, ph == 4 && !p_cmp);
    chk("rf_readnum", rf_readnum, ph == 1 ? p_rn : ph == 2 ? p_rm : 3'd0);
    if (ph == 4) chk("rf_writenum", rf_writenum, p_rd);
    chk("rf_data_in", rf_data_in, m_c);
    chk("status", status, m_st);
  end

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (rf_write) wr_cnt++;
  end

  task automatic wr(input logic [2:0] n, input logic [15:0] d);
    @(negedge clk); tb_we = 1; tb_wn = n; tb_wd = d;
    @(negedge clk); tb_we = 0;
  endtask

  task automatic op(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b,
                    input logic [1:0] sh, input logic [1:0] al, input logic c);
    @(negedge clk); start = 1; rd = d; rn = a; rm = b; shift_op = sh; alu_op = al; cmp = c;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    chk("lat_not_yet", done, 0);
    @(negedge clk);
    chk("lat_done_at_4", done, 1);
    @(negedge clk);
  endtask

  initial begin
    int dc, wc;
    logic [15:0] r6;
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_write", rf_write, 0);
    chk("rst_readnum", rf_readnum, 0); chk("rst_writenum", rf_writenum, 0);
    chk("rst_data_in", rf_data_in, 0); chk("rst_status", status, 0);
    @(negedge clk); reset = 0;
    for (int i = 0; i < 8; i++) wr(i[2:0], 16'h0);
    // 1: ADD 5+3
    wr(1, 16'd5); wr(2, 16'd3);
    op(3, 1, 2, 0, 0, 0);
    chk("t1_r3", regs[3], 16'd8); chk("t1_st", status, 3'b000);
    // 2: SUB R1-R1
    wr(1, 16'h1234);
    op(4, 1, 1, 0, 1, 0);
    chk("t2_r4", regs[4], 16'h0000); chk("t2_st", status, 3'b001);
    // 3: signed overflow
    wr(5, 16'h7FFF); wr(6, 16'h0001);
    op(7, 5, 6, 0, 0, 0);
    chk("t3_r7", regs[7], 16'h8000); chk("t3_st", status, 3'b110);
    // 4: MVN with ASR1 / LSR1
    wr(2, 16'h8001);
    op(0, 0, 2, 3, 3, 0);
    chk("t4_asr_r0", regs[0], 16'h3FFF); chk("t4_asr_st", status, 3'b000);
    op(0, 0, 2, 2, 3, 0);
    chk("t4_lsr_r0", regs[0], 16'hBFFF); chk("t4_lsr_st", status, 3'b010);
    // 5: start during RD_B ignored
    r6 = regs[6]; dc = done_cnt;
    @(negedge clk); start = 1; rd = 3; rn = 1; rm = 1; shift_op = 0; alu_op = 0; cmp = 0;
    @(negedge clk); start = 0;
    @(negedge clk); start = 1; rd = 6; rn = 5; rm = 5;
    @(negedge clk); start = 0;
    repeat (8) @(negedge clk);
    chk("t5_one_done", done_cnt - dc, 1); chk("t5_r6", regs[6], r6);
    chk("t5_r3", regs[3], 16'h2468);
    // 6: reset during EXEC
    op(4, 1, 1, 0, 1, 0);
    wc = wr_cnt;
    @(negedge clk); start = 1; rd = 5; rn = 1; rm = 2; alu_op = 0; shift_op = 0;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    reset = 1; #1;
    chk("t6_busy", busy, 0); chk("t6_status", status, 0); chk("t6_write", rf_write, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("t6_no_write", wr_cnt - wc, 0); chk("t6_r5", regs[5], 16'h7FFF);
`ifdef EXEC_CMP_EN
    // 7: compare-only
    wr(4, 16'hABCD); wc = wr_cnt;
    op(4, 1, 1, 0, 1, 1);
    chk("t7_r4", regs[4], 16'hABCD); chk("t7_st", status, 3'b001); chk("t7_nowrite", wr_cnt - wc, 0);
`endif
    // random ops checked by the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 7), $urandom);
      op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
         $urandom_range(0, 3), $urandom_range(0, 3),
`ifdef EXEC_CMP_EN
         $urandom_range(0, 3) == 0
`else
         1'b0
`endif
      );
    end
    for (int i = 0; i < 8; i++) chk("final_rf", regs[i], m_rf[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
